// File: rtl/huffman_pkg.sv
// Shared symbol and codeword definitions for the serial Huffman encoder and decoder.
package huffman_pkg;

  localparam int SYM_W       = 3;
  localparam int CODE_MAXLEN = 4;
  localparam int LEN_W       = 3;

  localparam logic [SYM_W-1:0] SYM_A = 3'd1;
  localparam logic [SYM_W-1:0] SYM_B = 3'd2;
  localparam logic [SYM_W-1:0] SYM_C = 3'd3;
  localparam logic [SYM_W-1:0] SYM_D = 3'd4;
  localparam logic [SYM_W-1:0] SYM_E = 3'd5;
  localparam logic [SYM_W-1:0] SYM_F = 3'd6;

  // Codewords are left-aligned so the MSB is always the next bit to emit.
  localparam logic [CODE_MAXLEN-1:0] CODE_A = 4'b0000;
  localparam logic [CODE_MAXLEN-1:0] CODE_B = 4'b1010;
  localparam logic [CODE_MAXLEN-1:0] CODE_C = 4'b1000;
  localparam logic [CODE_MAXLEN-1:0] CODE_D = 4'b1110;
  localparam logic [CODE_MAXLEN-1:0] CODE_E = 4'b1101;
  localparam logic [CODE_MAXLEN-1:0] CODE_F = 4'b1100;

  localparam logic [LEN_W-1:0] LEN_A = 3'd1;
  localparam logic [LEN_W-1:0] LEN_B = 3'd3;
  localparam logic [LEN_W-1:0] LEN_C = 3'd3;
  localparam logic [LEN_W-1:0] LEN_D = 3'd3;
  localparam logic [LEN_W-1:0] LEN_E = 3'd4;
  localparam logic [LEN_W-1:0] LEN_F = 3'd4;

endpackage

// File: rtl/huffman_code_rom.sv
// Combinational symbol-to-codeword lookup; codes 0 and 7 flag as invalid.
module huffman_code_rom
  import huffman_pkg::*;
(
  input  logic [2:0] sym,
  output logic [3:0] code,
  output logic [2:0] len,
  output logic       valid
);

  always_comb begin
    code  = '0;
    len   = '0;
    valid = 1'b1;
    case (sym)
      SYM_A: begin code = CODE_A; len = LEN_A; end
      SYM_B: begin code = CODE_B; len = LEN_B; end
      SYM_C: begin code = CODE_C; len = LEN_C; end
      SYM_D: begin code = CODE_D; len = LEN_D; end
      SYM_E: begin code = CODE_E; len = LEN_E; end
      SYM_F: begin code = CODE_F; len = LEN_F; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/huffman_encoder.sv
// Bit-serial Huffman encoder: valid/ready symbol intake, MSB-first gap-free codeword output.
module huffman_encoder
  import huffman_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       x,
  output logic       x_valid,
  output logic       sym_err
);

  logic [CODE_MAXLEN-1:0] sr;
  logic [LEN_W-1:0]       rem;
  logic [CODE_MAXLEN-1:0] rom_code;
  logic [LEN_W-1:0]       rom_len;
  logic                   rom_valid;
  logic                   accept;

  huffman_code_rom u_rom (
    .sym   (sym),
    .code  (rom_code),
    .len   (rom_len),
    .valid (rom_valid)
  );

  // Ready while the last bit is on x gives back-to-back codewords with no bubble.
  assign sym_ready = (rem <= 3'd1);
  assign accept    = sym_valid & sym_ready;
  assign x         = sr[CODE_MAXLEN-1];
  assign x_valid   = (rem != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      rem     <= '0;
      sym_err <= 1'b0;
    end else begin
      sym_err <= accept & ~rom_valid;
      if (accept) begin
        if (rom_valid) begin
          sr  <= rom_code;
          rem <= rom_len;
        end else begin
          sr  <= '0;
          rem <= '0;
        end
      end else if (rem > 3'd1) begin
        sr  <= sr << 1;
        rem <= rem - 3'd1;
      end else if (rem == 3'd1) begin
        sr  <= '0;
        rem <= '0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       x;
  logic       x_valid;
  logic       sym_err;

  int n_cmp = 0;
  int n_err = 0;

  huffman_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .x         (x),
    .x_valid   (x_valid),
    .sym_err   (sym_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_xv, input logic exp_x,
                         input logic exp_rdy, input logic exp_err);
    chk({tag, ".x_valid"},   x_valid,   exp_xv);
    chk({tag, ".x"},         x,         exp_x);
    chk({tag, ".sym_ready"}, sym_ready, exp_rdy);
    chk({tag, ".sym_err"},   sym_err,   exp_err);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] stream;
  int          idx;
  logic        acc;

  initial begin
    reset     = 1'b1;
    sym       = 3'd0;
    sym_valid = 1'b0;
    #3;
    chk_out("rst_hold", 0, 0, 1, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk_out("rst_rel", 0, 0, 1, 0);

    // Single A
    sym = 3'd1; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk_out("A_bit0", 1, 0, 1, 0);
    step();
    chk_out("A_idle", 0, 0, 1, 0);

    // E then B back-to-back
    sym = 3'd5; sym_valid = 1'b1;
    step();
    sym = 3'd2;
    chk_out("EB_b0", 1, 1, 0, 0);
    step();
    chk_out("EB_b1", 1, 1, 0, 0);
    step();
    chk_out("EB_b2", 1, 0, 0, 0);
    step();
    chk_out("EB_b3", 1, 1, 1, 0);
    step();
    sym_valid = 1'b0;
    chk_out("EB_b4", 1, 1, 0, 0);
    step();
    chk_out("EB_b5", 1, 0, 0, 0);
    step();
    chk_out("EB_b6", 1, 1, 1, 0);
    step();
    chk_out("EB_idle", 0, 0, 1, 0);

    // Invalid 0 and 7, then F
    sym = 3'd0; sym_valid = 1'b1;
    step();
    sym = 3'd7;
    chk_out("inv0", 0, 0, 1, 1);
    step();
    sym = 3'd6;
    chk_out("inv7", 0, 0, 1, 1);
    step();
    sym_valid = 1'b0;
    chk_out("F_b0", 1, 1, 0, 0);
    step();
    chk_out("F_b1", 1, 1, 0, 0);
    step();
    chk_out("F_b2", 1, 0, 0, 0);
    step();
    chk_out("F_b3", 1, 0, 1, 0);
    step();
    chk_out("F_idle", 0, 0, 1, 0);

    // Reset in the middle of F, then D
    sym = 3'd6; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk_out("Fr_b0", 1, 1, 0, 0);
    step();
    chk_out("Fr_b1", 1, 1, 0, 0);
    reset = 1'b1;
    #1;
    chk_out("Fr_async", 0, 0, 1, 0);
    step();
    reset = 1'b0;
    chk_out("Fr_held", 0, 0, 1, 0);
    step();
    chk_out("Fr_rel", 0, 0, 1, 0);
    sym = 3'd4; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk_out("D_b0", 1, 1, 0, 0);
    step();
    chk_out("D_b1", 1, 1, 0, 0);
    step();
    chk_out("D_b2", 1, 1, 1, 0);
    step();
    chk_out("D_idle", 0, 0, 1, 0);

    // Loop-back stream A..F: 0 101 100 111 1101 1100, gap-free
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    stream = 18'b0_101_100_111_1101_1100;
    idx = 0;
    sym = 3'd1; sym_valid = 1'b1;
    for (int k = 0; k < 18; k++) begin
      acc = sym_valid & sym_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 6) sym = 3'(idx + 1);
        else sym_valid = 1'b0;
      end
      chk($sformatf("loop_xv%0d", k), x_valid, 1'b1);
      chk($sformatf("loop_x%0d", k),  x,       stream[17-k]);
    end
    chk("loop_all_accepted", (idx == 6), 1'b1);
    step();
    chk_out("loop_idle", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
